video_timing_cfg_ctrl: RTL and testbench
========================================

Name: video_timing_cfg_ctrl

Overview:
Register-programmed controller that owns the configuration of video_timing. Software or the register decoder writes a shadow set of timing and mode values. On commit, the block copies the shadow set to the active outputs at a safe point and runs the config_sync_req/config_sync_ack handshake with video_timing. It also handles timeout and error reporting. It sits between the register decoder and video_timing, in the pixel-clock domain.

Parameters:
TIMEOUT_CYCLES, 2000000, cycles to wait for each ack edge before aborting (about two frames at 25 MHz).
TO_W, 21, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  pixel clock; the only clock.
reset  in  1  synchronous, active-high.
wr_en  in  1  register write strobe, one cycle.
wr_addr  in  4  register index.
wr_data  in  16  write data.
t_horiz_res  out  11  active horizontal resolution.
t_horiz_fp / t_horiz_sync_width / t_horiz_bp  out  8 each  horizontal front porch / sync width / back porch.
t_vert_res  out  10  active vertical resolution.
t_vert_fp / t_vert_sync_width / t_vert_bp  out  8 each  vertical front porch / sync width / back porch.
t_words_per_line_m1  out  8  DMA words per line, minus one.
t_bpp  out  2  bits-per-pixel code.
t_hires / t_double_x / t_double_y  out  1 each  mode bits.
v_cursor_x  out  11  cursor x; live value, not shadowed.
v_cursor_y / v_cursor_yend  out  10 each  cursor start / end line; live values.
enable_test_card  out  1  live test-card enable.
config_sync_req  out  1  request to video_timing.
config_sync_ack  in  1  ack from video_timing.
busy  out  1  commit in progress.
err  out  1  sticky error flag.

Behaviour:
- Register map; writes use the low bits of wr_data:
  - 0 HRES, 1 HFP, 2 HSW, 3 HBP, 4 VRES, 5 VFP, 6 VSW, 7 VBP, 8 WPL_M1.
  - 9 MODE: [1:0] bpp, [2] hires, [3] dx, [4] dy.
  - 10 CURX, 11 CURY, 12 CURYEND.
  - 13 CTRL: [0] commit (self-clearing), [1] test card, [2] err clear.
  - 14–15 ignored.
- Addresses 0–9 write the shadow set only. Addresses 10–12 and CTRL[1] update their outputs on the cycle after the write.
- Reset values:
  - Shadow and active sets: 1152/40/20/62, 896/4/3/47, WPL_M1=35, bpp=3, hires=1, dx=0, dy=0.
  - Cursor outputs 0; enable_test_card=1.
  - config_sync_req=0, busy=0, err=0; FSM in IDLE.
- FSM states:
  - IDLE: commit, or a pending commit, goes to COPY. busy=0.
  - COPY: one cycle; active <= shadow; clear pending; go to REQ.
  - REQ: config_sync_req=1; wait for config_sync_ack=1, then go to REL.
  - REL: config_sync_req=0; wait for config_sync_ack=0, then go to IDLE.
- busy=1 in every state except IDLE. busy is a registered output, high the cycle after the commit write.
- Timeout counter: cleared on entry to REQ and to REL; increments each cycle in those states. On reaching TIMEOUT_CYCLES: err<=1, config_sync_req<=0, go to IDLE. Active values are kept.
- Commit while busy sets the pending flag. Multiple commits while busy collapse into a single pending commit. Shadow writes while busy are accepted and are picked up by the pending commit.
- Commit in IDLE while pending is set: a single commit results.
- err clear and a new error in the same cycle: the set wins.
- Minimum latency: commit write at cycle N gives config_sync_req=1 at N+2.
- Reset mid-handshake: everything returns to reset values immediately, including req=0.
- Active outputs never change while in REQ or REL.

Optional Feature:
VIDEO_TIMING_CFG_VALIDATE_EN.
- Defined: COPY checks the shadow set first. A check fails if any of the following holds:
  - HRES=0, VRES=0, HSW=0 or VSW=0;
  - HRES+HFP+HSW+HBP > 2047 (12-bit sum);
  - VRES+VFP+VSW+VBP > 1023 (11-bit sum).
- On failure: err<=1, active values unchanged, no request, return to IDLE.
- Undefined: no checks; COPY copies unconditionally.

Decomposition:
- Package video_timing_cfg_pkg holds:
  - register address constants;
  - MODE and CTRL bit indices;
  - FSM state encoding;
  - reset-default constants.
- One natural sub-module: video_timing_cfg_regs (shadow and live register file plus write decode). The FSM and timeout counter live in the top module.

Test Plan:
- Reset, then idle 10 cycles -> outputs match the defaults (1152/896, WPL 35), req=0, busy=0, err=0.
- Write HRES=640 and VRES=480, commit at cycle N -> t_horiz_res=640 at N+2 together with req=1; the bench acks 70 cycles later then drops ack -> req falls next cycle, busy=0 after ack low.
- Three commits while in REQ -> after the first handshake completes, exactly one further REQ/REL sequence.
- Never ack -> after TIMEOUT_CYCLES (reduced to 100 in the bench) err=1, req=0, busy=0; CTRL[2] write -> err=0.
- CURX=0x69 written mid-handshake -> v_cursor_x=0x69 next cycle; timing outputs unchanged.
- With VIDEO_TIMING_CFG_VALIDATE_EN: HSW=0 then commit -> err=1, no req, active HSW stays 20.

Source files
------------

// File: rtl/video_timing_cfg_pkg.sv
// Shared definitions for the video_timing configuration controller: register map,
// CTRL/MODE bit positions, FSM encoding, timing-set struct and reset defaults.
package video_timing_cfg_pkg;

  localparam logic [3:0] ADDR_HRES    = 4'd0;
  localparam logic [3:0] ADDR_HFP     = 4'd1;
  localparam logic [3:0] ADDR_HSW     = 4'd2;
  localparam logic [3:0] ADDR_HBP     = 4'd3;
  localparam logic [3:0] ADDR_VRES    = 4'd4;
  localparam logic [3:0] ADDR_VFP     = 4'd5;
  localparam logic [3:0] ADDR_VSW     = 4'd6;
  localparam logic [3:0] ADDR_VBP     = 4'd7;
  localparam logic [3:0] ADDR_WPL_M1  = 4'd8;
  localparam logic [3:0] ADDR_MODE    = 4'd9;
  localparam logic [3:0] ADDR_CURX    = 4'd10;
  localparam logic [3:0] ADDR_CURY    = 4'd11;
  localparam logic [3:0] ADDR_CURYEND = 4'd12;
  localparam logic [3:0] ADDR_CTRL    = 4'd13;

  localparam int MODE_BPP_LSB = 0;
  localparam int MODE_BPP_MSB = 1;
  localparam int MODE_HIRES   = 2;
  localparam int MODE_DX      = 3;
  localparam int MODE_DY      = 4;

  localparam int CTRL_COMMIT    = 0;
  localparam int CTRL_TEST_CARD = 1;
  localparam int CTRL_ERR_CLR   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COPY = 2'd1,
    ST_REQ  = 2'd2,
    ST_REL  = 2'd3
  } cfg_state_t;

  typedef struct packed {
    logic [10:0] hres;
    logic [7:0]  hfp;
    logic [7:0]  hsw;
    logic [7:0]  hbp;
    logic [9:0]  vres;
    logic [7:0]  vfp;
    logic [7:0]  vsw;
    logic [7:0]  vbp;
    logic [7:0]  wpl_m1;
    logic [1:0]  bpp;
    logic        hires;
    logic        dx;
    logic        dy;
  } timing_cfg_t;

  localparam timing_cfg_t CFG_DEFAULT = '{
    hres:   11'd1152,
    hfp:    8'd40,
    hsw:    8'd20,
    hbp:    8'd62,
    vres:   10'd896,
    vfp:    8'd4,
    vsw:    8'd3,
    vbp:    8'd47,
    wpl_m1: 8'd35,
    bpp:    2'd3,
    hires:  1'b1,
    dx:     1'b0,
    dy:     1'b0
  };

  // Sums are sized one bit wider than the limit so an over-long line or frame
  // cannot wrap back into the legal range.
  function automatic logic cfg_valid(input timing_cfg_t c);
    logic [11:0] h_total;
    logic [10:0] v_total;
    h_total = 12'(c.hres) + 12'(c.hfp) + 12'(c.hsw) + 12'(c.hbp);
    v_total = 11'(c.vres) + 11'(c.vfp) + 11'(c.vsw) + 11'(c.vbp);
    return (c.hres != '0) && (c.vres != '0) && (c.hsw != '0) && (c.vsw != '0) &&
           (h_total <= 12'd2047) && (v_total <= 11'd1023);
  endfunction

endpackage

// File: rtl/video_timing_cfg_regs.sv
// Register file for the configuration controller: write decode, shadow timing set,
// active timing set (loaded on request) and the live cursor/test-card registers.
// Optional shadow validation is enabled by defining VIDEO_TIMING_CFG_VALIDATE_EN.
module video_timing_cfg_regs
  import video_timing_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        load_active,
  output timing_cfg_t active,
  output logic        shadow_ok,
  output logic [10:0] cursor_x,
  output logic [9:0]  cursor_y,
  output logic [9:0]  cursor_yend,
  output logic        test_card,
  output logic        commit,
  output logic        err_clr
);

  timing_cfg_t shadow;
  logic        ctrl_wr;
  logic        unused_wr_data;

  assign ctrl_wr        = wr_en && (wr_addr == ADDR_CTRL);
  assign commit         = ctrl_wr && wr_data[CTRL_COMMIT];
  assign err_clr        = ctrl_wr && wr_data[CTRL_ERR_CLR];
  assign unused_wr_data = ^wr_data[15:11];

`ifdef VIDEO_TIMING_CFG_VALIDATE_EN
  assign shadow_ok = cfg_valid(shadow);
`else
  assign shadow_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= CFG_DEFAULT;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_HRES:   shadow.hres   <= wr_data[10:0];
        ADDR_HFP:    shadow.hfp    <= wr_data[7:0];
        ADDR_HSW:    shadow.hsw    <= wr_data[7:0];
        ADDR_HBP:    shadow.hbp    <= wr_data[7:0];
        ADDR_VRES:   shadow.vres   <= wr_data[9:0];
        ADDR_VFP:    shadow.vfp    <= wr_data[7:0];
        ADDR_VSW:    shadow.vsw    <= wr_data[7:0];
        ADDR_VBP:    shadow.vbp    <= wr_data[7:0];
        ADDR_WPL_M1: shadow.wpl_m1 <= wr_data[7:0];
        ADDR_MODE: begin
          shadow.bpp   <= wr_data[MODE_BPP_MSB:MODE_BPP_LSB];
          shadow.hires <= wr_data[MODE_HIRES];
          shadow.dx    <= wr_data[MODE_DX];
          shadow.dy    <= wr_data[MODE_DY];
        end
        default: ;
      endcase
    end
  end

  // The active set only moves when the controller says it is safe to do so.
  always_ff @(posedge clk) begin
    if (reset) begin
      active <= CFG_DEFAULT;
    end else if (load_active) begin
      active <= shadow;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cursor_x    <= '0;
      cursor_y    <= '0;
      cursor_yend <= '0;
      test_card   <= 1'b1;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_CURX:    cursor_x    <= wr_data[10:0];
        ADDR_CURY:    cursor_y    <= wr_data[9:0];
        ADDR_CURYEND: cursor_yend <= wr_data[9:0];
        ADDR_CTRL:    test_card   <= wr_data[CTRL_TEST_CARD];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/video_timing_cfg_ctrl.sv
// Configuration controller for video_timing: commit FSM, sync handshake, timeout and
// sticky error. Define VIDEO_TIMING_CFG_VALIDATE_EN to reject bad shadow sets at commit.
module video_timing_cfg_ctrl
  import video_timing_cfg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int TO_W           = 21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [15:0] wr_data,
  output logic [10:0] t_horiz_res,
  output logic [7:0]  t_horiz_fp,
  output logic [7:0]  t_horiz_sync_width,
  output logic [7:0]  t_horiz_bp,
  output logic [9:0]  t_vert_res,
  output logic [7:0]  t_vert_fp,
  output logic [7:0]  t_vert_sync_width,
  output logic [7:0]  t_vert_bp,
  output logic [7:0]  t_words_per_line_m1,
  output logic [1:0]  t_bpp,
  output logic        t_hires,
  output logic        t_double_x,
  output logic        t_double_y,
  output logic [10:0] v_cursor_x,
  output logic [9:0]  v_cursor_y,
  output logic [9:0]  v_cursor_yend,
  output logic        enable_test_card,
  output logic        config_sync_req,
  input  logic        config_sync_ack,
  output logic        busy,
  output logic        err
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  cfg_state_t      state;
  logic            pending;
  logic [TO_W-1:0] to_cnt;
  timing_cfg_t     active;
  logic            shadow_ok;
  logic            commit;
  logic            err_clr;
  logic            load_active;

  assign load_active = (state == ST_COPY) && shadow_ok;

  video_timing_cfg_regs u_regs (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .load_active (load_active),
    .active      (active),
    .shadow_ok   (shadow_ok),
    .cursor_x    (v_cursor_x),
    .cursor_y    (v_cursor_y),
    .cursor_yend (v_cursor_yend),
    .test_card   (enable_test_card),
    .commit      (commit),
    .err_clr     (err_clr)
  );

  assign t_horiz_res         = active.hres;
  assign t_horiz_fp          = active.hfp;
  assign t_horiz_sync_width  = active.hsw;
  assign t_horiz_bp          = active.hbp;
  assign t_vert_res          = active.vres;
  assign t_vert_fp           = active.vfp;
  assign t_vert_sync_width   = active.vsw;
  assign t_vert_bp           = active.vbp;
  assign t_words_per_line_m1 = active.wpl_m1;
  assign t_bpp               = active.bpp;
  assign t_hires             = active.hires;
  assign t_double_x          = active.dx;
  assign t_double_y          = active.dy;

  // Handshake: req rises on COPY->REQ, falls once ack is seen high, and the
  // controller returns to IDLE once ack has dropped again.
  // Any error set below is placed after the err clear so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      pending         <= 1'b0;
      to_cnt          <= '0;
      config_sync_req <= 1'b0;
      busy            <= 1'b0;
      err             <= 1'b0;
    end else begin
      if (err_clr) begin
        err <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (commit || pending) begin
            state <= ST_COPY;
            busy  <= 1'b1;
          end
        end
        ST_COPY: begin
          pending <= 1'b0;
          if (shadow_ok) begin
            state           <= ST_REQ;
            config_sync_req <= 1'b1;
            to_cnt          <= '0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end
        end
        ST_REQ: begin
          if (config_sync_ack) begin
            state           <= ST_REL;
            config_sync_req <= 1'b0;
            to_cnt          <= '0;
          end else if (to_cnt == TO_LAST) begin
            state           <= ST_IDLE;
            config_sync_req <= 1'b0;
            busy            <= 1'b0;
            err             <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_REL: begin
          if (!config_sync_ack) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (to_cnt == TO_LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          state           <= ST_IDLE;
          config_sync_req <= 1'b0;
          busy            <= 1'b0;
        end
      endcase
      // A commit arriving while busy (including during COPY) is remembered once.
      if (commit && (state != ST_IDLE)) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_cfg_ctrl.sv
// Self-checking bench for video_timing_cfg_ctrl: register-map model, commit
// scoreboard, handshake, pending-commit, timeout, live registers and reset.
module tb_video_timing_cfg_ctrl;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [10:0] t_horiz_res;
  logic [7:0]  t_horiz_fp;
  logic [7:0]  t_horiz_sync_width;
  logic [7:0]  t_horiz_bp;
  logic [9:0]  t_vert_res;
  logic [7:0]  t_vert_fp;
  logic [7:0]  t_vert_sync_width;
  logic [7:0]  t_vert_bp;
  logic [7:0]  t_words_per_line_m1;
  logic [1:0]  t_bpp;
  logic        t_hires;
  logic        t_double_x;
  logic        t_double_y;
  logic [10:0] v_cursor_x;
  logic [9:0]  v_cursor_y;
  logic [9:0]  v_cursor_yend;
  logic        enable_test_card;
  logic        config_sync_req;
  logic        config_sync_ack;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  video_timing_cfg_ctrl #(.TIMEOUT_CYCLES(TMO), .TO_W(8)) dut (
    .clk                 (clk),
    .reset               (reset),
    .wr_en               (wr_en),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .t_horiz_res         (t_horiz_res),
    .t_horiz_fp          (t_horiz_fp),
    .t_horiz_sync_width  (t_horiz_sync_width),
    .t_horiz_bp          (t_horiz_bp),
    .t_vert_res          (t_vert_res),
    .t_vert_fp           (t_vert_fp),
    .t_vert_sync_width   (t_vert_sync_width),
    .t_vert_bp           (t_vert_bp),
    .t_words_per_line_m1 (t_words_per_line_m1),
    .t_bpp               (t_bpp),
    .t_hires             (t_hires),
    .t_double_x          (t_double_x),
    .t_double_y          (t_double_y),
    .v_cursor_x          (v_cursor_x),
    .v_cursor_y          (v_cursor_y),
    .v_cursor_yend       (v_cursor_yend),
    .enable_test_card    (enable_test_card),
    .config_sync_req     (config_sync_req),
    .config_sync_ack     (config_sync_ack),
    .busy                (busy),
    .err                 (err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: register contents indexed by register address.
  logic [15:0] m_shadow [0:9];
  logic [15:0] m_active [0:9];
  logic [10:0] m_curx;
  logic [9:0]  m_cury;
  logic [9:0]  m_curyend;
  logic        m_tc;
  logic [81:0] exp_q [$];

  logic [81:0] dut_active;
  assign dut_active = {t_horiz_res, t_horiz_fp, t_horiz_sync_width, t_horiz_bp,
                       t_vert_res, t_vert_fp, t_vert_sync_width, t_vert_bp,
                       t_words_per_line_m1, t_double_y, t_double_x, t_hires, t_bpp};

  function automatic logic [15:0] field_mask(input int a);
    case (a)
      0:       return 16'h07ff;
      4:       return 16'h03ff;
      9:       return 16'h001f;
      default: return 16'h00ff;
    endcase
  endfunction

  function automatic logic [81:0] pack_cfg(input bit use_shadow);
    logic [15:0] v [0:9];
    for (int i = 0; i < 10; i++) v[i] = use_shadow ? m_shadow[i] : m_active[i];
    return {v[0][10:0], v[1][7:0], v[2][7:0], v[3][7:0], v[4][9:0],
            v[5][7:0], v[6][7:0], v[7][7:0], v[8][7:0], v[9][4:0]};
  endfunction

  function automatic bit model_valid();
`ifdef VIDEO_TIMING_CFG_VALIDATE_EN
    int h;
    int v;
    h = int'(m_shadow[0]) + int'(m_shadow[1]) + int'(m_shadow[2]) + int'(m_shadow[3]);
    v = int'(m_shadow[4]) + int'(m_shadow[5]) + int'(m_shadow[6]) + int'(m_shadow[7]);
    return (m_shadow[0] != 0) && (m_shadow[4] != 0) && (m_shadow[2] != 0) &&
           (m_shadow[6] != 0) && (h <= 2047) && (v <= 1023);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    int defaults [0:9];
    defaults = '{1152, 40, 20, 62, 896, 4, 3, 47, 35, 7};
    for (int i = 0; i < 10; i++) begin
      m_shadow[i] = 16'(defaults[i]);
      m_active[i] = 16'(defaults[i]);
    end
    m_curx = '0;
    m_cury = '0;
    m_curyend = '0;
    m_tc = 1'b1;
    exp_q.delete();
  endtask

  task automatic model_commit_copy();
    for (int i = 0; i < 10; i++) m_active[i] = m_shadow[i];
  endtask

  // ---------------- clock/reset and drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    config_sync_ack = 1'b0;
    wr_en = 1'b0;
    tick();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic write_reg(input int a, input logic [15:0] d);
    wr_en = 1'b1;
    wr_addr = 4'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a <= 9) m_shadow[a] = d & field_mask(a);
    else if (a == 10) m_curx = d[10:0];
    else if (a == 11) m_cury = d[9:0];
    else if (a == 12) m_curyend = d[9:0];
    else if (a == 13) m_tc = d[1];
  endtask

  task automatic wait_req(input logic lvl, input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (config_sync_req === lvl) begin
        hit = 1'b1;
        return;
      end
      tick();
    end
    if (config_sync_req === lvl) hit = 1'b1;
  endtask

  task automatic wait_busy(input logic lvl, input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === lvl) begin
        hit = 1'b1;
        return;
      end
      tick();
    end
    if (busy === lvl) hit = 1'b1;
  endtask

  // Plays the video_timing side of one handshake and records what it saw.
  task automatic handshake(input int ack_dly, input int rel_dly, output bit got_req,
                           output logic [81:0] act, output bit stable, output bit done);
    bit hit;
    got_req = 1'b0;
    stable = 1'b1;
    done = 1'b0;
    act = '0;
    wait_req(1'b1, 10, hit);
    if (!hit) return;
    got_req = 1'b1;
    act = dut_active;
    repeat (ack_dly) begin
      tick();
      if (dut_active !== act || config_sync_req !== 1'b1) stable = 1'b0;
    end
    config_sync_ack = 1'b1;
    wait_req(1'b0, 10, hit);
    if (!hit) begin
      config_sync_ack = 1'b0;
      return;
    end
    repeat (rel_dly) begin
      tick();
      if (dut_active !== act || config_sync_req !== 1'b0) stable = 1'b0;
    end
    config_sync_ack = 1'b0;
    wait_busy(1'b0, 10, hit);
    done = hit;
    if (dut_active !== act) stable = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    repeat (10) tick();
    n_vec++;
    if (dut_active !== pack_cfg(1'b0)) begin
      n_err++;
      $display("FAIL reset_active: got %h expected %h", dut_active, pack_cfg(1'b0));
    end
    n_vec++;
    if (t_horiz_res !== 11'd1152 || t_vert_res !== 10'd896 || t_words_per_line_m1 !== 8'd35) begin
      n_err++;
      $display("FAIL reset_res: got %0d/%0d/%0d expected 1152/896/35",
               t_horiz_res, t_vert_res, t_words_per_line_m1);
    end
    n_vec++;
    if ({config_sync_req, busy, err} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got req/busy/err=%b expected 000", {config_sync_req, busy, err});
    end
    n_vec++;
    if ({v_cursor_x, v_cursor_y, v_cursor_yend, enable_test_card} !== {m_curx, m_cury, m_curyend, m_tc}) begin
      n_err++;
      $display("FAIL reset_live: got %h expected %h",
               {v_cursor_x, v_cursor_y, v_cursor_yend, enable_test_card}, {m_curx, m_cury, m_curyend, m_tc});
    end
  endtask

  task automatic test_commit_latency();
    bit hit;
    bit stable;
    logic [81:0] snap;
    do_reset();
    write_reg(0, 16'd640);
    write_reg(4, 16'd480);
    write_reg(13, 16'h0001);
    n_vec++;
    if (busy !== 1'b1 || config_sync_req !== 1'b0 || t_horiz_res !== 11'd1152) begin
      n_err++;
      $display("FAIL commit_n1: got busy=%b req=%b hres=%0d expected 1 0 1152",
               busy, config_sync_req, t_horiz_res);
    end
    tick();
    model_commit_copy();
    n_vec++;
    if (config_sync_req !== 1'b1 || t_horiz_res !== 11'd640 || t_vert_res !== 10'd480) begin
      n_err++;
      $display("FAIL commit_n2: got req=%b hres=%0d vres=%0d expected 1 640 480",
               config_sync_req, t_horiz_res, t_vert_res);
    end
    snap = pack_cfg(1'b0);
    stable = 1'b1;
    repeat (70) begin
      tick();
      if (config_sync_req !== 1'b1 || dut_active !== snap) stable = 1'b0;
    end
    n_vec++;
    if (stable !== 1'b1) begin
      n_err++;
      $display("FAIL req_hold: got stable=%b expected 1", stable);
    end
    config_sync_ack = 1'b1;
    tick();
    n_vec++;
    if (config_sync_req !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL ack_rel: got req=%b busy=%b expected 0 1", config_sync_req, busy);
    end
    config_sync_ack = 1'b0;
    wait_busy(1'b0, 3, hit);
    n_vec++;
    if (!hit || err !== 1'b0 || dut_active !== snap) begin
      n_err++;
      $display("FAIL release_done: got hit=%b err=%b expected 1 0", hit, err);
    end
  endtask

  task automatic test_random();
    bit got;
    bit stable;
    bit done;
    logic [81:0] act;
    logic [81:0] expv;
    do_reset();
    for (int it = 0; it < 12; it++) begin
      int nw;
      nw = $urandom_range(1, 4);
      for (int k = 0; k < nw; k++) write_reg($urandom_range(0, 9), 16'($urandom_range(0, 16'hffff)));
      write_reg(13, 16'h0001);
      if (model_valid()) begin
        model_commit_copy();
        exp_q.push_back(pack_cfg(1'b0));
        handshake($urandom_range(0, 20), $urandom_range(0, 10), got, act, stable, done);
        expv = exp_q.pop_front();
        n_vec++;
        if (!got || !done || !stable || act !== expv) begin
          n_err++;
          $display("FAIL rand_commit[%0d]: got %h (req=%b done=%b stable=%b) expected %h",
                   it, act, got, done, stable, expv);
        end
      end else begin
        repeat (3) tick();
        n_vec++;
        if (err !== 1'b1 || config_sync_req !== 1'b0 || busy !== 1'b0 || dut_active !== pack_cfg(1'b0)) begin
          n_err++;
          $display("FAIL rand_reject[%0d]: got err=%b req=%b busy=%b act=%h expected 1 0 0 %h",
                   it, err, config_sync_req, busy, dut_active, pack_cfg(1'b0));
        end
        write_reg(13, 16'h0004);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit hit;
    bit got;
    bit stable;
    bit done;
    int extra;
    logic [81:0] act;
    logic [81:0] expv;
    do_reset();
    write_reg(1, 16'($urandom_range(0, 255)));
    write_reg(13, 16'h0001);
    model_commit_copy();
    expv = pack_cfg(1'b0);
    wait_req(1'b1, 10, hit);
    n_vec++;
    if (!hit || dut_active !== expv) begin
      n_err++;
      $display("FAIL b2b_first: got hit=%b act=%h expected 1 %h", hit, dut_active, expv);
    end
    write_reg(13, 16'h0001);
    write_reg(2, 16'($urandom_range(1, 255)));
    write_reg(13, 16'h0001);
    write_reg(13, 16'h0001);
    config_sync_ack = 1'b1;
    wait_req(1'b0, 10, hit);
    config_sync_ack = 1'b0;
    wait_busy(1'b0, 10, hit);
    model_commit_copy();
    exp_q.push_back(pack_cfg(1'b0));
    handshake($urandom_range(1, 8), $urandom_range(0, 4), got, act, stable, done);
    expv = exp_q.pop_front();
    n_vec++;
    if (!got || !done || act !== expv) begin
      n_err++;
      $display("FAIL b2b_pending: got %h (req=%b done=%b) expected %h", act, got, done, expv);
    end
    extra = 0;
    repeat (30) begin
      tick();
      if (config_sync_req === 1'b1 || busy === 1'b1) extra++;
    end
    n_vec++;
    if (extra !== 0) begin
      n_err++;
      $display("FAIL b2b_collapse: got %0d extra busy cycles expected 0", extra);
    end
  endtask

  task automatic test_timeout();
    bit hit;
    int hi;
    do_reset();
    write_reg(3, 16'($urandom_range(1, 255)));
    write_reg(13, 16'h0001);
    model_commit_copy();
    wait_req(1'b1, 10, hit);
    hi = 0;
    while (config_sync_req === 1'b1 && hi < 300) begin
      tick();
      hi++;
    end
    n_vec++;
    if (!hit || hi < TMO - 1 || hi > TMO + 1) begin
      n_err++;
      $display("FAIL timeout_len: got %0d req cycles expected %0d", hi, TMO);
    end
    n_vec++;
    if (err !== 1'b1 || config_sync_req !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_flags: got err=%b req=%b busy=%b expected 1 0 0", err, config_sync_req, busy);
    end
    n_vec++;
    if (dut_active !== pack_cfg(1'b0)) begin
      n_err++;
      $display("FAIL timeout_kept: got %h expected %h", dut_active, pack_cfg(1'b0));
    end
    write_reg(13, 16'h0004);
    n_vec++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clear: got %b expected 0", err);
    end
  endtask

  task automatic test_cursor_live();
    bit hit;
    bit got;
    bit stable;
    bit done;
    logic [81:0] act;
    do_reset();
    write_reg(13, 16'h0001);
    model_commit_copy();
    wait_req(1'b1, 10, hit);
    write_reg(10, 16'h0069);
    n_vec++;
    if (v_cursor_x !== 11'h069 || dut_active !== pack_cfg(1'b0)) begin
      n_err++;
      $display("FAIL curx_live: got %h act=%h expected 069 %h", v_cursor_x, dut_active, pack_cfg(1'b0));
    end
    write_reg(11, 16'($urandom_range(0, 16'hffff)));
    write_reg(12, 16'($urandom_range(0, 16'hffff)));
    write_reg(13, 16'h0000);
    n_vec++;
    if ({v_cursor_y, v_cursor_yend, enable_test_card} !== {m_cury, m_curyend, m_tc} ||
        config_sync_req !== 1'b1) begin
      n_err++;
      $display("FAIL live_regs: got %h req=%b expected %h 1",
               {v_cursor_y, v_cursor_yend, enable_test_card}, config_sync_req, {m_cury, m_curyend, m_tc});
    end
    handshake(2, 2, got, act, stable, done);
    n_vec++;
    if (!got || !done || act !== pack_cfg(1'b0)) begin
      n_err++;
      $display("FAIL live_finish: got %h (req=%b done=%b) expected %h", act, got, done, pack_cfg(1'b0));
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    do_reset();
    write_reg(0, 16'd800);
    write_reg(13, 16'h0001);
    wait_req(1'b1, 10, hit);
    config_sync_ack = 1'b1;
    do_reset();
    n_vec++;
    if (config_sync_req !== 1'b0 || busy !== 1'b0 || err !== 1'b0 || dut_active !== pack_cfg(1'b0)) begin
      n_err++;
      $display("FAIL reset_mid: got req=%b busy=%b err=%b act=%h expected 0 0 0 %h",
               config_sync_req, busy, err, dut_active, pack_cfg(1'b0));
    end
  endtask

`ifdef VIDEO_TIMING_CFG_VALIDATE_EN
  task automatic test_validate();
    int req_seen;
    do_reset();
    write_reg(2, 16'h0000);
    write_reg(13, 16'h0001);
    req_seen = 0;
    repeat (5) begin
      tick();
      if (config_sync_req === 1'b1) req_seen++;
    end
    n_vec++;
    if (err !== 1'b1 || req_seen !== 0 || t_horiz_sync_width !== 8'd20 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL validate_hsw0: got err=%b req_cycles=%0d hsw=%0d busy=%b expected 1 0 20 0",
               err, req_seen, t_horiz_sync_width, busy);
    end
    write_reg(13, 16'h0004);
  endtask
`endif

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    config_sync_ack = 1'b0;
    test_reset();
    test_commit_latency();
    test_random();
    test_back_to_back();
    test_timeout();
    test_cursor_live();
    test_reset_mid();
`ifdef VIDEO_TIMING_CFG_VALIDATE_EN
    test_validate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

endmodule
